// File: rtl/seg_display_driver.sv
// Time-multiplexed 4-digit seven-segment driver: frame-coherent snapshot,
// guarded anode scan, per-digit blink, all outputs registered and active-low.
module seg_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] GUARD_CNT    = RW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_HALF - 1);

  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [15:0]   snap_digit_q, snap_digit_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic [3:0]    snap_blink_q, snap_blink_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          slot_end;
  logic          blank;
  logic [3:0]    cur_digit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end  = (refresh_q == REFRESH_LAST);
    refresh_d = slot_end ? '0 : refresh_q + 1'b1;
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;

    blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
    phase_d = (blink_q == BLINK_LAST) ? ~phase_q : phase_q;

    // New values are only taken at the frame boundary so a frame never mixes old and new digits.
    snap_digit_d = snap_digit_q;
    snap_dp_d    = snap_dp_q;
    snap_blink_d = snap_blink_q;
    if (slot_end && idx_q == 2'd3) begin
      snap_digit_d = digits_in;
      snap_dp_d    = dp_in;
      snap_blink_d = blink_mask;
    end

    cur_digit = snap_digit_q[{idx_q, 2'b00} +: 4];
    blank = ~enable | (refresh_q < GUARD_CNT) | (phase_q & snap_blink_q[idx_q]);
    if (blank) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(cur_digit);
      dp_d  = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q    <= '0;
      idx_q        <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      snap_digit_q <= digits_in;
      snap_dp_q    <= dp_in;
      snap_blink_q <= blink_mask;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      refresh_q    <= refresh_d;
      idx_q        <= idx_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      snap_digit_q <= snap_digit_d;
      snap_dp_q    <= snap_dp_d;
      snap_blink_q <= snap_blink_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: a time-arithmetic reference model checked
// every cycle, plus hand-computed literal expectations at key points of the scan.
module tb_seg_display_driver;

  localparam int R = 8;
  localparam int G = 2;
  localparam int B = 64;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        enable;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;

  seg_display_driver #(.REFRESH_DIV(R), .GUARD(G), .BLINK_HALF(B)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .enable(enable), .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: k = edges since reset release; slot, digit and blink phase follow from k directly.
  int         k = 0;
  bit         modelValid = 0;
  logic [15:0] mDig;
  logic [3:0]  mDp, mBlink;
  logic [3:0]  expAn;
  logic [6:0]  expSeg;
  logic        expDp;

  always @(posedge clk) begin
    int mIdx, mPos, mPhase;
    bit mBlank;
    if (rst) begin
      k = 0;
      mDig = digits_in; mDp = dp_in; mBlink = blink_mask;
      expAn = 4'b1111; expSeg = 7'b1111111; expDp = 1'b1;
      modelValid = 1;
    end else if (modelValid) begin
      mIdx   = (k / R) % 4;
      mPos   = k % R;
      mPhase = (k / B) % 2;
      mBlank = !enable || (mPos < G) || (mPhase == 1 && mBlink[mIdx]);
      if (mBlank) begin
        expAn = 4'b1111; expSeg = 7'b1111111; expDp = 1'b1;
      end else begin
        expAn  = 4'b1111;
        expAn[mIdx] = 1'b0;
        expSeg = segTable[mDig[mIdx*4 +: 4]];
        expDp  = ~mDp[mIdx];
      end
      if (k % (4 * R) == 4 * R - 1) begin
        mDig = digits_in; mDp = dp_in; mBlink = blink_mask;
      end
      k = k + 1;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      vectors++;
      if (an !== expAn || seg !== expSeg || dp !== expDp) begin
        miscompares++;
        $display("[TB] FAIL model t=%0t k=%0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 $time, k, an, seg, dp, expAn, expSeg, expDp);
      end
      vectors++;
      if ($countones(~an) > 1) begin
        miscompares++;
        $display("[TB] FAIL onehot t=%0t: an=%b, want at most one low bit", $time, an);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] wAn,
                             input logic [6:0] wSeg, input logic wDp);
    vectors++;
    if (an !== wAn || seg !== wSeg || dp !== wDp) begin
      miscompares++;
      $display("[TB] FAIL %s: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, an, seg, dp, wAn, wSeg, wDp);
    end
  endtask

  task automatic checkAn(input string name, input logic [3:0] wAn);
    vectors++;
    if (an !== wAn) begin
      miscompares++;
      $display("[TB] FAIL %s: an=%b, want an=%b", name, an, wAn);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] m, input logic e);
    digits_in = d; dp_in = p; blink_mask = m; enable = e;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b1);
    waitCycles(3);
    checkOutput("reset_state", 4'b1111, 7'b1111111, 1'b1);
    rst = 1'b0;

    // Startup scan: cycles counted from reset release.
    waitCycles(1); checkAn("startup_c1", 4'b1111);
    waitCycles(1); checkAn("startup_c2", 4'b1111);
    waitCycles(1); checkOutput("startup_d0", 4'b1110, 7'b0011001, 1'b1);
    waitCycles(8); checkOutput("startup_d1", 4'b1101, 7'b0110000, 1'b1);

    // Cycle 11: in the digit-1 slot, change inputs mid-frame.
    applyStimulus(16'h8888, 4'b0000, 4'b0000, 1'b1);
    waitCycles(8);  checkOutput("coherent_d2", 4'b1011, 7'b0100100, 1'b1);
    waitCycles(8);  checkOutput("coherent_d3", 4'b0111, 7'b1111001, 1'b1);
    waitCycles(8);  checkOutput("newframe_d0", 4'b1110, 7'b0000000, 1'b1);

    // Cycle 35: blink digit 0; loaded at k=64 where phase is already 1.
    applyStimulus(16'h8888, 4'b0000, 4'b0001, 1'b1);
    waitCycles(32); checkOutput("blink_off_d0", 4'b1111, 7'b1111111, 1'b1);
    waitCycles(8);  checkOutput("blink_d1_unaffected", 4'b1101, 7'b0000000, 1'b1);
    waitCycles(56); checkOutput("blink_on_d0", 4'b1110, 7'b0000000, 1'b1);

    // Cycle 131: decimal point on digit 2, loaded at k=160.
    applyStimulus(16'h8888, 4'b0100, 4'b0000, 1'b1);
    waitCycles(48); checkOutput("dp_d2", 4'b1011, 7'b0000000, 1'b0);
    waitCycles(8);  checkOutput("dp_d3_off", 4'b0111, 7'b0000000, 1'b1);

    applyStimulus(16'h8888, 4'b0100, 4'b0000, 1'b0);
    waitCycles(1);  checkOutput("disable_blank", 4'b1111, 7'b1111111, 1'b1);
    waitCycles(40);
    applyStimulus(16'h8888, 4'b0100, 4'b0000, 1'b1);

    for (int v = 0; v < 16; v++) begin
      applyStimulus({12'h000, 4'(v)}, 4'b0100, 4'b0000, 1'b1);
      waitCycles(4 * R);
    end

    // Reset in the middle of the digit-2 slot.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((k / R) % 4 == 2 && k % R == 4) found = 1;
      else waitCycles(1);
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("[TB] FAIL midscan_wait: slot not reached, want idx=2 slot within 200 cycles");
    end
    rst = 1'b1;
    waitCycles(1); checkOutput("midscan_reset", 4'b1111, 7'b1111111, 1'b1);
    rst = 1'b0;
    waitCycles(1); checkAn("restart_c1", 4'b1111);
    waitCycles(2); checkOutput("restart_d0", 4'b1110, 7'b0001110, 1'b1);
    waitCycles(8); checkOutput("restart_d1", 4'b1101, 7'b1000000, 1'b1);
    waitCycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
